// File: rtl/servo_ctrl_sched.sv
// Servo-loop sequencer for the pan/tilt head: frame-synchronised threshold capture,
// period-aligned PWM for both servos, and one XADC DRP feedback read pair per period.
module servo_ctrl_sched #(
    parameter int         CLK_DIV     = 100,
    parameter int         PERIOD_US   = 20000,
    parameter int         THRES_MIN   = 800,
    parameter int         THRES_MAX   = 2300,
    parameter int         THRES_RST   = 1500,
    parameter logic [6:0] ADDR_A      = 7'h1E,
    parameter logic [6:0] ADDR_B      = 7'h16,
    parameter int         DRP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic [14:0] thres_x,
    input  logic [14:0] thres_y,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] measured_aux_a,
    output logic [15:0] measured_aux_b,
    output logic        meas_valid,
    output logic        drp_timeout,
    output logic        pwm_x,
    output logic        pwm_y,
    output logic        period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int TW = $clog2(DRP_TIMEOUT + 1);
    localparam logic [14:0] T_RST = 15'(THRES_RST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_A,
        S_WAIT_A,
        S_REQ_B,
        S_WAIT_B,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            timeout_hit;
    logic [TW-1:0]   timer;

    logic            vs_meta;
    logic            vs_sync;
    logic            vs_prev;
    logic            frame_tick;

    logic [PW-1:0]   pre_cnt;
    logic [UW-1:0]   us_cnt;
    logic            tick;
    logic            wrap;

    logic [14:0]     pend_x;
    logic [14:0]     pend_y;
    logic [14:0]     act_x;
    logic [14:0]     act_y;

    function automatic logic [14:0] clamp_thres(input logic [14:0] t);
        logic [14:0] r;
        if (32'(t) < 32'(THRES_MIN))      r = 15'(THRES_MIN);
        else if (32'(t) > 32'(THRES_MAX)) r = 15'(THRES_MAX);
        else                              r = t;
        return r;
    endfunction

    // vsync is asynchronous: two flops to settle it, a third to find the rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vsync_in;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_tick = vs_sync & ~vs_prev;

    assign tick = (pre_cnt == PW'(CLK_DIV - 1));
    assign wrap = tick && (us_cnt == UW'(PERIOD_US - 1));

    // Active thresholds only move at the wrap, so a pulse is never cut or stretched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            us_cnt       <= '0;
            pend_x       <= T_RST;
            pend_y       <= T_RST;
            act_x        <= T_RST;
            act_y        <= T_RST;
            period_start <= 1'b0;
            pwm_x        <= 1'b0;
            pwm_y        <= 1'b0;
        end else begin
            if (tick) pre_cnt <= '0;
            else      pre_cnt <= pre_cnt + 1'b1;

            if (wrap) begin
                us_cnt <= '0;
                act_x  <= pend_x;
                act_y  <= pend_y;
            end else if (tick) begin
                us_cnt <= us_cnt + 1'b1;
            end

            if (frame_tick) begin
                pend_x <= clamp_thres(thres_x);
                pend_y <= clamp_thres(thres_y);
            end

            period_start <= wrap;
            pwm_x        <= (32'(us_cnt) < 32'(act_x));
            pwm_y        <= (32'(us_cnt) < 32'(act_y));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Data arriving in the expiry cycle wins over the timeout.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        drp_den     = 1'b0;
        drp_daddr   = 7'h00;
        meas_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (period_start) state_nxt = S_REQ_A;
            end
            S_REQ_A: begin
                drp_den   = 1'b1;
                drp_daddr = ADDR_A;
                state_nxt = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (drp_drdy) begin
                    state_nxt = S_REQ_B;
                end else if (timer == TW'(DRP_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_REQ_B;
                end
            end
            S_REQ_B: begin
                drp_den   = 1'b1;
                drp_daddr = ADDR_B;
                state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (drp_drdy) begin
                    state_nxt = S_DONE;
                end else if (timer == TW'(DRP_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                meas_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign drp_dwe = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer          <= '0;
            drp_timeout    <= 1'b0;
            measured_aux_a <= 16'h0000;
            measured_aux_b <= 16'h0000;
        end else begin
            drp_timeout <= timeout_hit;
            if (state == S_REQ_A || state == S_REQ_B) timer <= '0;
            else if (state == S_WAIT_A || state == S_WAIT_B) timer <= timer + 1'b1;

            if (state == S_WAIT_A && drp_drdy) measured_aux_a <= drp_do;
            if (state == S_WAIT_B && drp_drdy) measured_aux_b <= drp_do;
        end
    end

endmodule

// File: tb/tb_servo_ctrl_sched.sv
// Bench for servo_ctrl_sched: period-by-period pulse widths, DRP read pairs and
// reset behaviour against a threshold/readback model built from the period rules.
module tb_servo_ctrl_sched;

    localparam int CLK_DIV   = 4;
    localparam int PERIOD_US = 2500;
    localparam int PCLK      = CLK_DIV * PERIOD_US;
    localparam int T_MIN     = 800;
    localparam int T_MAX     = 2300;
    localparam int T_RST     = 1500;
    localparam int DRP_TO    = 255;
    localparam logic [6:0] ADDR_A = 7'h1E;
    localparam logic [6:0] ADDR_B = 7'h16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync_in;
    logic [14:0] thres_x;
    logic [14:0] thres_y;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] measured_aux_a;
    logic [15:0] measured_aux_b;
    logic        meas_valid;
    logic        drp_timeout;
    logic        pwm_x;
    logic        pwm_y;
    logic        period_start;

    always #5 clk = ~clk;

    servo_ctrl_sched #(
        .CLK_DIV   (CLK_DIV),
        .PERIOD_US (PERIOD_US)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vsync_in       (vsync_in),
        .thres_x        (thres_x),
        .thres_y        (thres_y),
        .drp_do         (drp_do),
        .drp_drdy       (drp_drdy),
        .drp_den        (drp_den),
        .drp_dwe        (drp_dwe),
        .drp_daddr      (drp_daddr),
        .measured_aux_a (measured_aux_a),
        .measured_aux_b (measured_aux_b),
        .meas_valid     (meas_valid),
        .drp_timeout    (drp_timeout),
        .pwm_x          (pwm_x),
        .pwm_y          (pwm_y),
        .period_start   (period_start)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending/active thresholds in µs and last good readbacks.
    int          m_pend_x, m_pend_y, m_act_x, m_act_y;
    logic [15:0] m_aux_a, m_aux_b;
    logic [6:0]  exp_q[$];

    int          resp_cnt = 0;
    logic [15:0] resp_data;
    int          vs_hold  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input logic [14:0] t);
        int v;
        v = int'(t);
        if (v < T_MIN) return T_MIN;
        if (v > T_MAX) return T_MAX;
        return v;
    endfunction

    function automatic logic [14:0] rand_thres();
        case ($urandom_range(0, 3))
            0:       return 15'($urandom_range(0, T_MIN - 1));
            1:       return 15'($urandom_range(T_MAX + 1, 32767));
            default: return 15'($urandom_range(T_MIN, T_MAX));
        endcase
    endfunction

    task automatic model_reset();
        m_pend_x = T_RST;
        m_pend_y = T_RST;
        m_act_x  = T_RST;
        m_act_y  = T_RST;
        m_aux_a  = 16'h0000;
        m_aux_b  = 16'h0000;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_den"},          32'(drp_den),        32'd0);
        chk({tag, "_dwe"},          32'(drp_dwe),        32'd0);
        chk({tag, "_daddr"},        32'(drp_daddr),      32'd0);
        chk({tag, "_meas_valid"},   32'(meas_valid),     32'd0);
        chk({tag, "_timeout"},      32'(drp_timeout),    32'd0);
        chk({tag, "_period_start"}, 32'(period_start),   32'd0);
        chk({tag, "_pwm_x"},        32'(pwm_x),          32'd0);
        chk({tag, "_pwm_y"},        32'(pwm_y),          32'd0);
        chk({tag, "_aux_a"},        32'(measured_aux_a), 32'd0);
        chk({tag, "_aux_b"},        32'(measured_aux_b), 32'd0);
    endtask

    // One servo period: sample index 0 is the cycle showing period_start (or reset release).
    // lat_* = 0 means the responder ignores that read; stop_at > 0 abandons the period early.
    task automatic run_window(input bit first, input int lat_a, input int lat_b,
                              input logic [15:0] data_a, input logic [15:0] data_b,
                              input int vs_at, input logic [14:0] nx, input logic [14:0] ny,
                              input int spur_at, input int stop_at);
        int hx, hy, ps_mid, ps_end, den_n, mv_n, to_n, dwe_n, den_a_idx, to_idx, lat, exp_to;
        logic [6:0] exp_addr;
        hx = 0; hy = 0; ps_mid = 0; ps_end = 0; den_n = 0; mv_n = 0;
        to_n = 0; dwe_n = 0; den_a_idx = -1; to_idx = -1;
        if (!first) begin
            exp_q.push_back(ADDR_A);
            exp_q.push_back(ADDR_B);
        end
        for (int i = 1; i <= PCLK; i++) begin
            @(negedge clk);
            if (i == stop_at) return;
            hx    += int'(pwm_x);
            hy    += int'(pwm_y);
            dwe_n += int'(drp_dwe);
            mv_n  += int'(meas_valid);
            if (i < PCLK) ps_mid += int'(period_start);
            else          ps_end  = int'(period_start);
            if (drp_timeout === 1'b1) begin
                to_n++;
                to_idx = i;
            end
            drp_drdy = 1'b0;
            if (vs_hold > 0) begin
                vs_hold--;
                if (vs_hold == 0) vsync_in = 1'b0;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = resp_data;
                end
            end
            if (drp_den === 1'b1) begin
                den_n++;
                if (exp_q.size() > 0) begin
                    exp_addr = exp_q.pop_front();
                    chk("drp_daddr", 32'(drp_daddr), 32'(exp_addr));
                end else begin
                    chk("drp_den_unexpected", 32'(drp_den), 32'd0);
                end
                lat = (den_n == 1) ? lat_a : lat_b;
                if (den_n == 1) den_a_idx = i;
                if (lat > 0) begin
                    resp_cnt  = lat;
                    resp_data = (den_n == 1) ? data_a : data_b;
                    if (den_n == 1) m_aux_a = data_a;
                    else            m_aux_b = data_b;
                end
            end
            if (i == spur_at) begin
                drp_drdy = 1'b1;
                drp_do   = 16'($urandom);
            end
            if (i == vs_at) begin
                thres_x  = nx;
                thres_y  = ny;
                vsync_in = 1'b1;
                vs_hold  = 8;
            end
        end

        exp_to = first ? 0 : (int'(lat_a == 0) + int'(lat_b == 0));
        chk("pwm_x_high_clk", hx, m_act_x * CLK_DIV);
        chk("pwm_y_high_clk", hy, m_act_y * CLK_DIV);
        chk("period_start_mid", ps_mid, 0);
        chk("period_start_end", ps_end, 1);
        chk("den_count", den_n, first ? 0 : 2);
        chk("meas_valid_count", mv_n, first ? 0 : 1);
        chk("timeout_count", to_n, exp_to);
        chk("dwe_high_cycles", dwe_n, 0);
        chk("aux_a", 32'(measured_aux_a), 32'(m_aux_a));
        chk("aux_b", 32'(measured_aux_b), 32'(m_aux_b));
        if (!first) chk("den_a_latency", den_a_idx, 1);
        if (!first && lat_a == 0) chk("timeout_cycle", to_idx, 2 + DRP_TO);

        // Active value for the next period is whatever pend holds in the cycle before the wrap.
        if (vs_at > 0 && vs_at + 3 <= PCLK - 1) begin
            m_pend_x = clamp(nx);
            m_pend_y = clamp(ny);
            m_act_x  = m_pend_x;
            m_act_y  = m_pend_y;
        end else if (vs_at > 0) begin
            m_act_x  = m_pend_x;
            m_act_y  = m_pend_y;
            m_pend_x = clamp(nx);
            m_pend_y = clamp(ny);
        end else begin
            m_act_x = m_pend_x;
            m_act_y = m_pend_y;
        end
    endtask

    initial begin
        int la;
        rst_n    = 1'b0;
        vsync_in = 1'b0;
        thres_x  = 15'(T_RST);
        thres_y  = 15'(T_RST);
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drp_drdy = 1'($urandom_range(0, 1));
            drp_do   = 16'($urandom);
        end
        @(negedge clk);
        drp_drdy = 1'b0;
        chk_reset("por");
        model_reset();
        rst_n = 1'b1;

        // First period runs from reset release with the reset thresholds.
        run_window(1'b1, 0, 0, 16'h0, 16'h0, -1, 15'd0, 15'd0, -1, 0);
        // Normal read pair; new thresholds captured mid-period, applied next period.
        run_window(1'b0, 3, 3, 16'hA5A0, 16'h5A50, 4000, 15'd1000, 15'd3000, -1, 0);
        // x=1000, y clamped to 2300; A read times out; y drops to 800 next.
        run_window(1'b0, 0, $urandom_range(1, 60), 16'($urandom), 16'($urandom),
                   3000, 15'd1000, 15'd100, -1, 0);
        // drdy lands in the expiry cycle; vsync edge coincides with the wrap.
        run_window(1'b0, DRP_TO, $urandom_range(1, 60), 16'($urandom), 16'($urandom),
                   PCLK - 3, rand_thres(), rand_thres(), -1, 0);
        // Quiet period with a stray drdy while idle.
        run_window(1'b0, $urandom_range(1, 40), $urandom_range(1, 40), 16'($urandom),
                   16'($urandom), -1, 15'd0, 15'd0, 6000, 0);
        // Threshold from the wrap-aligned vsync now active; fresh random update.
        run_window(1'b0, $urandom_range(1, 40), $urandom_range(1, 40), 16'($urandom),
                   16'($urandom), $urandom_range(2000, 9000), rand_thres(), rand_thres(), -1, 0);

        // Reset while waiting on the B read and while pwm_x is high.
        la = $urandom_range(2, 10);
        run_window(1'b0, la, 200, 16'($urandom), 16'($urandom), -1, 15'd0, 15'd0, -1, 60);
        chk("pwm_x_before_reset", 32'(pwm_x), 32'(60 <= m_act_x * CLK_DIV));
        drp_drdy = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk_reset("mid_op");
        model_reset();
        exp_q.delete();
        rst_n = 1'b1;
        // The outstanding B response arrives after release and must be ignored.
        run_window(1'b1, 0, 0, 16'h0, 16'h0, -1, 15'd0, 15'd0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/servo_ctrl_sched.md
# servo_ctrl_sched

Servo-loop sequencer for the ball-tracking pan/tilt head. It synchronises the camera frame strobe and captures the per-axis pulse-width thresholds from the x/y threshold generators. It applies those thresholds on 20 ms servo-period boundaries and drives the two servo PWM pins. Once per period it schedules two XADC DRP reads of the servo feedback pots, which supply the measured positions consumed by the threshold generators.

## Interface

**Parameters**
- `CLK_DIV`, default 100: clk cycles per 1 µs tick.
- `PERIOD_US`, default 20000: servo period in µs. Must exceed `THRES_MAX`.
- `THRES_MIN`, default 800: lower clamp in µs.
- `THRES_MAX`, default 2300: upper clamp in µs.
- `THRES_RST`, default 1500: threshold value after reset.
- `ADDR_A`, default 7'h1E: DRP address of the x feedback AUX channel.
- `ADDR_B`, default 7'h16: DRP address of the y feedback AUX channel.
- `DRP_TIMEOUT`, default 255: maximum clk cycles to wait for `drp_drdy`.

**Ports**
- `clk` in, 1 bit: system clock (100 MHz).
- `rst_n` in, 1 bit: synchronous, active-low reset.
- `vsync_in` in, 1 bit: camera vertical sync, asynchronous to `clk`.
- `thres_x` in, 15 bits: x-axis pulse width in µs from the x threshold generator.
- `thres_y` in, 15 bits: y-axis pulse width in µs from the y threshold generator.
- `drp_do` in, 16 bits: XADC DRP read data.
- `drp_drdy` in, 1 bit: XADC DRP data ready.
- `drp_den` out, 1 bit: DRP enable, one-cycle pulse.
- `drp_dwe` out, 1 bit: DRP write enable, tied to 0.
- `drp_daddr` out, 7 bits: DRP address.
- `measured_aux_a` out, 16 bits: last good x feedback sample.
- `measured_aux_b` out, 16 bits: last good y feedback sample.
- `meas_valid` out, 1 bit: one-cycle pulse when a read pair completes.
- `drp_timeout` out, 1 bit: one-cycle pulse when a read times out.
- `pwm_x` out, 1 bit: x servo PWM.
- `pwm_y` out, 1 bit: y servo PWM.
- `period_start` out, 1 bit: one-cycle pulse at the start of each servo period.

## Operation

**Frame capture**
- `vsync_in` passes through a 2-flop synchroniser, then a rising-edge detect produces `frame_tick`.
- On `frame_tick`, `pend_x` and `pend_y` load the clamped values of `thres_x` and `thres_y` (clamp range `THRES_MIN`..`THRES_MAX`).

**Period timing**
- The prescaler counts 0..`CLK_DIV`-1. `tick` asserts in the cycle where the count equals `CLK_DIV`-1.
- `us_cnt` counts 0..`PERIOD_US`-1 and advances only on `tick`.
- At wrap (on `tick` with `us_cnt`=`PERIOD_US`-1):
  - `us_cnt` returns to 0.
  - `act_x` ← `pend_x` and `act_y` ← `pend_y`.
  - `period_start` pulses on the next cycle.
- Thresholds never change mid-pulse.

**PWM outputs**
- `pwm_x` = (`us_cnt` < `act_x`), registered. `pwm_y` is the same with `act_y`.

**DRP scheduler FSM**

| State | Action | Transition |
|---|---|---|
| IDLE | Wait. | `period_start` → REQ_A. |
| REQ_A | `drp_den`=1, `drp_daddr`=`ADDR_A` for one cycle; clear timer. | → WAIT_A. |
| WAIT_A | Wait for data. | `drp_drdy` → `measured_aux_a` ← `drp_do`, go to REQ_B. Timer=`DRP_TIMEOUT`-1 without `drdy` → pulse `drp_timeout`, keep old value, go to REQ_B. |
| REQ_B | Same as REQ_A with `ADDR_B`. | → WAIT_B. |
| WAIT_B | Same as WAIT_A, capturing into `measured_aux_b`. | → DONE. |
| DONE | Pulse `meas_valid`; it pulses even if a timeout occurred. | → IDLE. |

**Boundary rules**
- `drp_drdy` in any state other than WAIT_A or WAIT_B is ignored.
- `drp_drdy` in the same cycle as the timeout: data wins and no timeout pulse is issued.
- `period_start` while not in IDLE is dropped. It is not queued.
- `frame_tick` in the same cycle as the period wrap: `act` takes the old `pend`, and `pend` takes the new value, which applies next period.
- Thresholds of 0 or ≥32768 cannot occur after clamping.

**Reset**
- Holding `rst_n`=0 on any clk edge returns everything to reset values, including mid-read or mid-pulse.
- Outstanding DRP responses after reset are ignored, because the FSM is in IDLE.

## Timing

**Reset values**
- Prescaler=0 and `us_cnt`=0.
- `pend_x/y` and `act_x/y` = `THRES_RST`.
- FSM=IDLE.
- `drp_den`, `drp_dwe`, `drp_daddr`, `meas_valid`, `drp_timeout`, `period_start`, `pwm_x` and `pwm_y` = 0.
- `measured_aux_a/b` = 16'h0000.

**Latencies**
- `vsync_in` rising edge to `pend` updated: 3–4 clk.
- Wrap `tick` to `period_start`: 1 clk. `period_start` to `drp_den`: 1 clk.
- `drp_drdy` to `measured_aux` updated: next edge.
- WAIT_B capture to `meas_valid`: 1 clk.
- PWM edges lag their `us_cnt` transition by 1 clk.
- High time = `act`×`CLK_DIV` clk. Period = `PERIOD_US`×`CLK_DIV` clk.

**First period after reset**
- The first period starts at reset release without a `period_start` pulse.
- The first pulse follows the first wrap.

## Test plan

Sim parameters: `CLK_DIV`=4, `PERIOD_US`=2500.

1. **Reset, no activity.** Apply reset, then run 2 periods with no vsync → `pwm_x` and `pwm_y` high for 6000 clk per 10000-clk period; one `period_start` per 10000 clk.
2. **Threshold update and clamp.** `thres_x`=1000, `thres_y`=3000, pulse `vsync` mid-period → current period is unchanged at 1500 µs; next period x high 4000 clk, y high 9200 clk (clamped to 2300). Then `thres_y`=100 with another vsync → y high 3200 clk (clamped to 800).
3. **Normal DRP pair.** Responder returns 16'hA5A0 for `ADDR_A` and 16'h5A50 for `ADDR_B` after 3 clk each → `drp_den` pulses exactly twice with `daddr` 1E then 16; `measured_aux_a`=A5A0, `measured_aux_b`=5A50; one `meas_valid` pulse; `drp_dwe`=0 throughout.
4. **Timeout.** Responder ignores `ADDR_A` → `drp_timeout` pulses exactly 255 clk after WAIT_A entry; `measured_aux_a` keeps its prior value; the B read still proceeds; `meas_valid` pulses.
5. **Simultaneous events.** `vsync` edge aligned with the wrap cycle → new threshold appears one period later. `drdy` in the cycle the timer expires → data captured, no `drp_timeout`. Spurious `drdy` in IDLE → no output change.
6. **Reset mid-operation.** Assert `rst_n`=0 during WAIT_B and while `pwm_x`=1 → next edge all outputs at reset values; a late `drdy` after release does not update `measured_aux_b`.
